// File: rtl/multdiv_coproc.sv
// Iterative radix-2 multiply/divide coprocessor with tagged valid/ready ports.
// Works on operand magnitudes for WIDTH cycles, then applies signs and exceptions.
module multdiv_coproc #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [TAG_W-1:0] busy_tag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_MULU = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic               neg_q, neg_a, dz_q, ovf_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   res_q;
  logic               exc_q;

  logic               accept, in_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign in_div   = (in_op == OP_DIV) | (in_op == OP_REM);
  assign a_neg    = in_a[WIDTH-1] & (in_op != OP_MULU);
  assign b_neg    = in_b[WIDTH-1] & (in_op != OP_MULU);
  assign a_mag    = a_neg ? -in_a : in_a;
  assign b_mag    = b_neg ? -in_b : in_b;

  logic               div_q, ge;
  logic [WIDTH:0]     top, sum;
  logic [WIDTH-1:0]   rem_w;
  logic [2*WIDTH-1:0] step, sprod;
  logic [WIDTH-1:0]   lo, hi, fin_res;
  logic               fin_exc;

  assign div_q = (op_q == OP_DIV) | (op_q == OP_REM);

  // Restoring divide step or shift-add multiply step on the magnitudes.
  always_comb begin
    top   = acc[2*WIDTH-1:WIDTH-1];
    ge    = top >= {1'b0, mcand};
    rem_w = top[WIDTH-1:0] - mcand;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    if (div_q)
      step = {(ge ? rem_w : top[WIDTH-1:0]), acc[WIDTH-2:0], ge};
    else
      step = {sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    hi      = step[2*WIDTH-1:WIDTH];
    lo      = step[WIDTH-1:0];
    sprod   = neg_q ? -step : step;
    fin_res = '0;
    fin_exc = 1'b0;
    unique case (op_q)
      OP_MUL: begin
        fin_res = sprod[WIDTH-1:0];
        fin_exc = sprod[2*WIDTH-1:WIDTH] != {WIDTH{sprod[WIDTH-1]}};
      end
      OP_MULU: begin
        fin_res = lo;
        fin_exc = |hi;
      end
      OP_DIV: begin
        fin_res = dz_q ? '0 : (neg_q ? -lo : lo);
        fin_exc = dz_q | ovf_q;
      end
      OP_REM: begin
        fin_res = dz_q ? '0 : (neg_a ? -hi : hi);
        fin_exc = dz_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      mcand <= '0;
      neg_q <= 1'b0;
      neg_a <= 1'b0;
      dz_q  <= 1'b0;
      ovf_q <= 1'b0;
      tag_q <= '0;
      res_q <= '0;
      exc_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state <= RUN;
      cnt   <= '0;
      op_q  <= in_op;
      tag_q <= in_tag;
      acc   <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
      mcand <= in_div ? b_mag : a_mag;
      neg_q <= a_neg ^ b_neg;
      neg_a <= a_neg;
      dz_q  <= in_b == '0;
      ovf_q <= (in_op == OP_DIV) & (in_a == {1'b1, {(WIDTH-1){1'b0}}})
             & (&in_b);
    end else begin
      case (state)
        RUN: begin
          acc <= step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state <= DONE;
            res_q <= fin_res;
            exc_q <= fin_exc;
          end
        end
        DONE:    if (out_ready) state <= IDLE;
        default: ;
      endcase
    end
  end

  assign out_valid     = state == DONE;
  assign out_result    = out_valid ? res_q : '0;
  assign out_exception = out_valid & exc_q;
  assign out_tag       = out_valid ? tag_q : '0;
  assign busy          = state != IDLE;
  assign busy_tag      = busy ? tag_q : '0;

endmodule

// File: tb/tb_multdiv_coproc.sv
// Bench for multdiv_coproc at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_multdiv_coproc;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        in_valid, flush, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid, out_exception, busy;
  logic [31:0] out_result;
  logic [4:0]  out_tag, busy_tag;

  logic        in_valid8, flush8, out_ready8;
  logic [1:0]  in_op8;
  logic [7:0]  in_a8, in_b8;
  logic [4:0]  in_tag8;
  logic        in_ready8, out_valid8, out_exception8, busy8;
  logic [7:0]  out_result8;
  logic [4:0]  out_tag8, busy_tag8;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_coproc #(.WIDTH(32), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exception(out_exception),
    .out_tag(out_tag), .busy(busy), .busy_tag(busy_tag)
  );

  multdiv_coproc #(.WIDTH(8), .TAG_W(5)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
    .in_a(in_a8), .in_b(in_b8), .in_tag(in_tag8), .flush(flush8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .out_exception(out_exception8),
    .out_tag(out_tag8), .busy(busy8), .busy_tag(busy_tag8)
  );

  function automatic longint sext(input int w, input longint unsigned v);
    if (((v >> (w-1)) & 64'd1) != 0)
      return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic void ref_model(input int w, input logic [1:0] op,
      input longint unsigned a, input longint unsigned b,
      output longint unsigned res, output bit exc);
    longint unsigned mask, pu;
    longint sa, sb, p, minv;
    mask = (64'd1 << w) - 64'd1;
    sa   = sext(w, a & mask);
    sb   = sext(w, b & mask);
    minv = -(longint'(1) << (w-1));
    res  = 0;
    exc  = 1'b0;
    case (op)
      2'd0: begin
        p   = sa * sb;
        res = longint'(p) & mask;
        exc = p != sext(w, res);
      end
      2'd3: begin
        pu  = (a & mask) * (b & mask);
        res = pu & mask;
        exc = (pu >> w) != 0;
      end
      2'd1: begin
        if (sb == 0) exc = 1'b1;
        else if (sa == minv && sb == -1) begin
          res = 64'd1 << (w-1);
          exc = 1'b1;
        end else res = longint'(sa / sb) & mask;
      end
      default: begin
        if (sb == 0) exc = 1'b1;
        else res = longint'(sa % sb) & mask;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      default: return 8'($urandom());
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    @(negedge clock);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Entered just after the accept edge; lat counts edges until out_valid.
  task automatic wait_result(input logic [4:0] tag, output int lat,
                             output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    @(negedge clock);
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1 || busy_tag !== tag) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdy=%b vld=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    n_tests++;
    if (out_result !== 32'h0 || out_exception !== 1'b0 ||
        out_tag !== 5'h0 || busy_tag !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_data: res=%h exc=%b tag=%h btag=%h want zeros",
               out_result, out_exception, out_tag, busy_tag);
    end
  endtask

  task automatic test_vectors();
    logic [1:0]  t_op [9] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd1,
                              2'd0, 2'd3, 2'd2, 2'd2};
    logic [31:0] t_a  [9] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5,
                              32'h8000_0000, 32'h0001_0000, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd5};
    logic [31:0] t_b  [9] = '{32'hFFFF_FFFA, 32'd2, 32'd2, 32'd0,
                              32'hFFFF_FFFF, 32'h0001_0000, 32'd1,
                              32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_r  [9] = '{32'hFFFF_FFD6, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF,
                              32'd0, 32'd0};
    logic        t_e  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b1};
    int lat;
    bit bok;
    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 5'(i + 3));
      wait_result(5'(i + 3), lat, bok);
      n_tests++;
      if (lat !== 32 || !bok) begin
        n_fail++;
        $display("FAIL vec%0d_timing: lat=%0d busy_ok=%0d want 32 1",
                 i, lat, bok);
      end
      n_tests++;
      if (out_result !== t_r[i] || out_exception !== t_e[i] ||
          out_tag !== 5'(i + 3)) begin
        n_fail++;
        $display("FAIL vec%0d_result: got %h/%b/%0d want %h/%b/%0d", i,
                 out_result, out_exception, out_tag, t_r[i], t_e[i], i + 3);
      end
      retire();
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    longint unsigned er;
    bit ee, bok;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick32();
      b   = pick32();
      tag = 5'($urandom());
      ref_model(32, op, 64'(a), 64'(b), er, ee);
      issue(op, a, b, tag);
      wait_result(tag, lat, bok);
      n_tests++;
      if (lat !== 32 || !bok || out_result !== er[31:0] ||
          out_exception !== ee || out_tag !== tag) begin
        n_fail++;
        $display("FAIL rand%0d op%0d %h,%h: got %h/%b/%0d lat%0d want %h/%b/%0d",
                 i, op, a, b, out_result, out_exception, out_tag, lat,
                 er[31:0], ee, tag);
      end
      retire();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit bok, stable;
    issue(2'd3, 32'hFFFF_FFFF, 32'd1, 5'd7);
    wait_result(5'd7, lat, bok);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF ||
          out_exception !== 1'b0 || out_tag !== 5'd7 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL hold_stable: got %b/%h/%0d rdy=%b want 1/ffffffff/7 rdy=0",
               out_valid, out_result, out_tag, in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'd1;
    in_a      = 32'd100;
    in_b      = 32'd7;
    in_tag    = 5'd9;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 1", in_ready);
    end
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy_tag !== 5'd9) begin
      n_fail++;
      $display("FAIL b2b_accept: vld=%b btag=%0d want 0 9", out_valid, busy_tag);
    end
    wait_result(5'd9, lat, bok);
    n_tests++;
    if (lat !== 32 || out_result !== 32'd14 || out_tag !== 5'd9) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d res=%h tag=%0d want 32 0000000e 9",
               lat, out_result, out_tag);
    end
    retire();
  endtask

  task automatic test_flush();
    int seen;
    int lat;
    bit bok;
    issue(2'd0, 32'd123, 32'd456, 5'd4);
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || busy_tag !== 5'd0 || in_ready !== 1'b1 ||
        out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_run: busy=%b btag=%0d rdy=%b vld=%b want 0 0 1 0",
               busy, busy_tag, in_ready, out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: out_valid high %0d cycles want 0", seen);
    end
    issue(2'd1, 32'd9, 32'd3, 5'd6);
    wait_result(5'd6, lat, bok);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_done: vld=%b busy=%b res=%h want 0 0 0",
               out_valid, busy, out_result);
    end
  endtask

  task automatic test_async_reset();
    issue(2'd1, 32'd1000, 32'd3, 5'd12);
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        busy_tag !== 5'd0 || out_tag !== 5'd0 || out_result !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b rdy=%b vld=%b btag=%0d want 0 1 0 0",
               busy, in_ready, out_valid, busy_tag);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: vld=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_width8();
    logic [1:0] op;
    logic [7:0] a, b;
    logic [4:0] tag;
    longint unsigned er;
    bit ee;
    int lat;
    for (int i = 0; i < 25; i++) begin
      if (i < 3) begin
        op = 2'(i);
        a  = (i == 0) ? 8'd7 : 8'hF9;
        b  = (i == 0) ? 8'hFA : 8'd2;
      end else begin
        op = 2'($urandom_range(0, 3));
        a  = pick8();
        b  = pick8();
      end
      tag = 5'(i);
      ref_model(8, op, 64'(a), 64'(b), er, ee);
      @(negedge clock);
      in_valid8 = 1'b1;
      in_op8    = op;
      in_a8     = a;
      in_b8     = b;
      in_tag8   = tag;
      @(posedge clock);
      #1;
      in_valid8 = 1'b0;
      lat = 0;
      @(negedge clock);
      while (out_valid8 !== 1'b1 && lat < 50) begin
        @(negedge clock);
        lat++;
      end
      n_tests++;
      if (lat !== 8 || out_result8 !== er[7:0] || out_exception8 !== ee ||
          out_tag8 !== tag) begin
        n_fail++;
        $display("FAIL w8_%0d op%0d %h,%h: got %h/%b/%0d lat%0d want %h/%b/%0d",
                 i, op, a, b, out_result8, out_exception8, out_tag8, lat,
                 er[7:0], ee, tag);
      end
      out_ready8 = 1'b1;
      @(negedge clock);
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_op     = 2'd0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    in_valid8 = 1'b0;
    flush8    = 1'b0;
    out_ready8 = 1'b0;
    in_op8    = 2'd0;
    in_a8     = '0;
    in_b8     = '0;
    in_tag8   = '0;
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_coproc.md
Name: multdiv_coproc

Overview:
- Parametrised, decoupled iterative multiply/divide coprocessor for the pipelined core; replaces the fixed 32-bit multdiv-plus-input-latch pair.
- Accepts one operation per valid/ready handshake together with a destination-register tag. Computes over a fixed WIDTH-cycle iteration, then presents result, exception and tag on a valid/ready output port.
- Exports busy and busy_tag so stall logic stalls only dependent instructions. A flush input cancels work squashed by a taken branch or jump.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- TAG_W, 5, width of the destination tag carried with each operation.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  2  00 MUL signed, 01 DIV signed, 10 REM signed, 11 MULU unsigned.
- in_a  in  WIDTH  operand A (multiplicand / dividend).
- in_b  in  WIDTH  operand B (multiplier / divisor).
- in_tag  in  TAG_W  destination register of the operation.
- flush  in  1  cancel any in-flight or held operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  WIDTH  low WIDTH bits of result.
- out_exception  out  1  overflow or divide-by-zero.
- out_tag  out  TAG_W  tag of the presented result.
- busy  out  1  high in RUN or DONE.
- busy_tag  out  TAG_W  tag of the operation held in RUN or DONE (0 when IDLE).

Behaviour:
- Reset (async, immediate): state IDLE, iteration counter 0. in_ready=1. out_valid=0, out_result=0, out_exception=0, out_tag=0, busy=0, busy_tag=0.
- FSM states: IDLE, RUN, DONE.
- Accept: on a rising edge with in_valid & in_ready & ~flush. Latch op, operands and tag; counter cleared; go to RUN.
- in_ready = (IDLE) | (DONE & out_ready). This allows back-to-back operation: the result is retired and the next operation accepted on the same edge.
- RUN: one radix-2 iteration per edge. After exactly WIDTH iterations, go to DONE. out_valid becomes visible WIDTH cycles after the accept edge. Latency is identical for all ops and all operand values, including divide-by-zero.
- DONE: out_valid=1. Outputs are held stable while out_ready=0. On an edge with out_ready=1, go to IDLE, or directly back to RUN if a new op is accepted on that edge.
- Flush: highest priority after reset. On an edge with flush=1, go to IDLE from any state; no accept on that edge; any held result is discarded. out_valid is low in the following cycle.
- MUL: signed two's-complement product. out_result = low WIDTH bits. out_exception=1 iff the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
- MULU: unsigned product. out_result = low WIDTH bits. out_exception=1 iff the upper WIDTH bits are nonzero.
- DIV: signed quotient, truncated toward zero. REM: signed remainder, with the sign of the dividend.
- Divide by zero (DIV or REM): out_result=0, out_exception=1.
- MIN / -1 (MIN = 1 followed by WIDTH-1 zeros):
  - DIV: out_result=MIN, out_exception=1.
  - REM: out_result=0, out_exception=0.
- Result registers are written only when entering DONE. out_result, out_exception and out_tag read 0 whenever out_valid=0.

Test Plan:
- WIDTH=32. Accept MUL a=7, b=-6 (0xFFFFFFFA), tag=3 -> out_valid rises exactly 32 cycles after accept; result 0xFFFFFFD6, exception=0, tag=3. busy=1 and busy_tag=3 throughout.
- DIV a=-7, b=2 -> result 0xFFFFFFFD (-3), exc=0. REM with the same operands -> result 0xFFFFFFFF (-1), exc=0.
- DIV a=5, b=0 -> result 0, exc=1, after 32 cycles. DIV a=0x80000000, b=-1 -> result 0x80000000, exc=1.
- MUL 0x00010000*0x00010000 -> result 0, exc=1. MULU 0xFFFFFFFF*1 -> result 0xFFFFFFFF, exc=0.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0. Then set out_ready=1 with a new in_valid -> retire and accept on the same edge; second result arrives 32 cycles later.
- Assert flush at iteration 10 -> IDLE next cycle; no out_valid ever appears for that op.
- Assert reset asynchronously mid-RUN, between clock edges -> all outputs 0 and in_ready=1 immediately.
- Repeat the MUL/DIV/REM vectors with WIDTH=8: 7*-6 -> 0xD6 in 8 cycles; -7/2 -> 0xFD.
